// File: rtl/rstrt_pkg.sv
// ============================================================================
// rstrt_pkg : state encodings, parameter defaults and helpers for restart_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package rstrt_pkg;

  localparam logic [2:0] ST_IDLE    = 3'b000;
  localparam logic [2:0] ST_HOLDOFF = 3'b001;
  localparam logic [2:0] ST_MONITOR = 3'b010;
  localparam logic [2:0] ST_RESTART = 3'b011;
  localparam logic [2:0] ST_W4DROP  = 3'b100;
  localparam logic [2:0] ST_W4RUN   = 3'b101;
  localparam logic [2:0] ST_FAIL    = 3'b110;

  localparam logic [7:0]  LOCK_FILT_DEF = 8'd16;
  localparam logic [15:0] HOLDOFF_DEF   = 16'd1000;
  localparam logic [15:0] RUN_TMO_DEF   = 16'd50000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lock_filt.sv
// ============================================================================
// lock_filt : counts consecutive lock-loss cycles, flags expiry on the Nth one
// Rev 1.0
// ============================================================================
`default_nettype none

module lock_filt
  import rstrt_pkg::*;
#(
  parameter logic [7:0] LOCK_FILT = LOCK_FILT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic loss,
  output logic expired
);

  logic [7:0] cnt;
  logic       at_last;

  assign at_last = (cnt == LOCK_FILT - 8'd1);
  // Combinational so the transition happens in the Nth consecutive loss cycle.
  assign expired = loss && !clear && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clear || !loss) begin
      cnt <= 8'd0;
    end else if (!at_last) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/restart_ctrl.sv
// ============================================================================
// restart_ctrl : supervises clock locks after power-on and issues sequencer
//                restarts on command or persistent lock loss
// Rev 1.0
// ============================================================================
`default_nettype none

module restart_ctrl
  import rstrt_pkg::*;
#(
  parameter logic [7:0]  LOCK_FILT = LOCK_FILT_DEF,
  parameter logic [15:0] HOLDOFF   = HOLDOFF_DEF,
  parameter logic [15:0] RUN_TMO   = RUN_TMO_DEF
) (
  input  logic       CLK,
  input  logic       EOS,
  input  logic       RUN,
  input  logic       QPLL_LOCK,
  input  logic       MMCM_LOCK,
  input  logic       AUTO_EN,
  input  logic       JTAG_RESTART,
  input  logic       CLR_FAIL,
  output logic       RESTART_ALL,
  output logic       LOCK_LOST,
  output logic       RSTRT_FAIL,
  output logic [7:0] RSTRT_CNT,
  output logic [2:0] RSTRT_STATE
);

  logic [2:0]  state;
  logic [2:0]  nextstate;
  logic [15:0] timer;
  logic        pending;
  logic        loss;
  logic        filt_clear;
  logic        expired;
  logic        timer_run;
  logic        lock_trig;
  logic        enter_restart;
  logic        enter_fail;
  logic        pend_set;

  assign loss       = !QPLL_LOCK || !MMCM_LOCK;
  assign filt_clear = !AUTO_EN || (state != ST_MONITOR) || !loss;

  lock_filt #(
    .LOCK_FILT(LOCK_FILT)
  ) u_lock_filt (
    .clk    (CLK),
    .rst_n  (EOS),
    .clear  (filt_clear),
    .loss   (loss),
    .expired(expired)
  );

  always_comb begin
    nextstate = state;
    case (state)
      ST_IDLE: begin
        if (RUN) nextstate = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (!RUN)                             nextstate = ST_IDLE;
        else if (timer == HOLDOFF - 16'd1)    nextstate = ST_MONITOR;
      end
      ST_MONITOR: begin
        if (JTAG_RESTART || pending || expired) nextstate = ST_RESTART;
        else if (!RUN)                          nextstate = ST_IDLE;
      end
      ST_RESTART: begin
        nextstate = ST_W4DROP;
      end
      ST_W4DROP: begin
        if (!RUN)                             nextstate = ST_W4RUN;
        else if (timer == RUN_TMO - 16'd1)    nextstate = ST_FAIL;
      end
      ST_W4RUN: begin
        if (RUN)                              nextstate = ST_HOLDOFF;
        else if (timer == RUN_TMO - 16'd1)    nextstate = ST_FAIL;
      end
      ST_FAIL: begin
        if (CLR_FAIL) nextstate = ST_IDLE;
      end
      default: nextstate = ST_IDLE;
    endcase
  end

  assign timer_run     = (state == ST_HOLDOFF) || (state == ST_W4DROP) || (state == ST_W4RUN);
  assign enter_restart = (nextstate == ST_RESTART) && (state != ST_RESTART);
  assign enter_fail    = (nextstate == ST_FAIL) && (state != ST_FAIL);
  // A command or pending request takes precedence over a coincident filter expiry.
  assign lock_trig     = (state == ST_MONITOR) && expired && !JTAG_RESTART && !pending;
  assign pend_set      = JTAG_RESTART && (state != ST_MONITOR) && (state != ST_FAIL);

  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      state       <= ST_IDLE;
      timer       <= 16'd0;
      pending     <= 1'b0;
      RESTART_ALL <= 1'b0;
      RSTRT_FAIL  <= 1'b0;
      LOCK_LOST   <= 1'b0;
      RSTRT_CNT   <= 8'd0;
    end else begin
      state <= nextstate;

      if (nextstate != state) begin
        timer <= 16'd0;
      end else if (timer_run) begin
        timer <= timer + 16'd1;
      end

      if (enter_restart || enter_fail) begin
        pending <= 1'b0;
      end else if (pend_set) begin
        pending <= 1'b1;
      end

      RESTART_ALL <= (nextstate == ST_RESTART);
      RSTRT_FAIL  <= (nextstate == ST_FAIL);

      if (nextstate == ST_RESTART) begin
        RSTRT_CNT <= sat_inc8(RSTRT_CNT);
        if (lock_trig) LOCK_LOST <= 1'b1;
      end
    end
  end

  assign RSTRT_STATE = state;

endmodule

`default_nettype wire

// File: tb/tb_restart_ctrl.sv
// ============================================================================
// tb_restart_ctrl : directed scenarios with a restart-pulse scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_restart_ctrl;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_HOLD = 3'b001;
  localparam logic [2:0] S_MON  = 3'b010;
  localparam logic [2:0] S_RST  = 3'b011;
  localparam logic [2:0] S_W4D  = 3'b100;
  localparam logic [2:0] S_W4R  = 3'b101;
  localparam logic [2:0] S_FAIL = 3'b110;

  logic       CLK = 1'b0;
  logic       EOS, RUN, QPLL_LOCK, MMCM_LOCK, AUTO_EN, JTAG_RESTART, CLR_FAIL;
  logic       RESTART_ALL, LOCK_LOST, RSTRT_FAIL;
  logic [7:0] RSTRT_CNT;
  logic [2:0] RSTRT_STATE;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] exp_cnt = 8'd0;

  always #5 CLK = ~CLK;

  restart_ctrl #(
    .LOCK_FILT(8'd4),
    .HOLDOFF  (16'd8),
    .RUN_TMO  (16'd20)
  ) dut (
    .CLK         (CLK),
    .EOS         (EOS),
    .RUN         (RUN),
    .QPLL_LOCK   (QPLL_LOCK),
    .MMCM_LOCK   (MMCM_LOCK),
    .AUTO_EN     (AUTO_EN),
    .JTAG_RESTART(JTAG_RESTART),
    .CLR_FAIL    (CLR_FAIL),
    .RESTART_ALL (RESTART_ALL),
    .LOCK_LOST   (LOCK_LOST),
    .RSTRT_FAIL  (RSTRT_FAIL),
    .RSTRT_CNT   (RSTRT_CNT),
    .RSTRT_STATE (RSTRT_STATE)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic ll);
    exp_cnt = (exp_cnt == 8'hFF) ? exp_cnt : exp_cnt + 8'd1;
    exp_q.push_back({ll, exp_cnt});
  endtask

  task automatic goto_monitor();
    RUN = 1'b1;
    tick();
    chk("enter_holdoff", {13'd0, RSTRT_STATE}, {13'd0, S_HOLD});
    repeat (7) tick();
    chk("holdoff_last", {13'd0, RSTRT_STATE}, {13'd0, S_HOLD});
    tick();
    chk("enter_monitor", {13'd0, RSTRT_STATE}, {13'd0, S_MON});
  endtask

  // Called one cycle into Restart; walks W4Drop -> W4Run -> Holdoff -> Monitor.
  task automatic back_to_monitor();
    RUN = 1'b0;
    tick();
    tick();
    chk("w4run_reached", {13'd0, RSTRT_STATE}, {13'd0, S_W4R});
    goto_monitor();
  endtask

  task automatic do_restart(input logic ll);
    push_exp(ll);
    JTAG_RESTART = 1'b1;
    tick();
    JTAG_RESTART = 1'b0;
    chk("jtag_restart_state", {13'd0, RSTRT_STATE}, {13'd0, S_RST});
    back_to_monitor();
  endtask

  // Scoreboard monitor: every RESTART_ALL pulse must match a queued expectation.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge CLK);
      if (RESTART_ALL === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_restart: RESTART_ALL=1 with nothing expected, state=%0d (t=%0t)",
                   RSTRT_STATE, $time);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_cnt", {8'd0, RSTRT_CNT}, {8'd0, e[7:0]});
          chk("pulse_lock_lost", {15'd0, LOCK_LOST}, {15'd0, e[8]});
          chk("pulse_state", {13'd0, RSTRT_STATE}, {13'd0, S_RST});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    EOS = 1'b0; RUN = 1'b0; QPLL_LOCK = 1'b1; MMCM_LOCK = 1'b1;
    AUTO_EN = 1'b0; JTAG_RESTART = 1'b0; CLR_FAIL = 1'b0;
    repeat (3) tick();
    chk("rst_state", {13'd0, RSTRT_STATE}, {13'd0, S_IDLE});
    chk("rst_outputs", {12'd0, RESTART_ALL, LOCK_LOST, RSTRT_FAIL, 1'b0}, 16'd0);
    chk("rst_cnt", {8'd0, RSTRT_CNT}, 16'd0);
    EOS = 1'b1;
    repeat (3) tick();
    chk("idle_waits", {13'd0, RSTRT_STATE}, {13'd0, S_IDLE});

    // Scenario 1: JTAG restart from Monitor
    goto_monitor();
    repeat (2) tick();
    do_restart(1'b0);

    // Scenario 2: lock-loss filter
    AUTO_EN = 1'b1;
    MMCM_LOCK = 1'b0;
    repeat (3) tick();
    MMCM_LOCK = 1'b1;
    repeat (3) tick();
    chk("filt_3_no_restart", {13'd0, RSTRT_STATE}, {13'd0, S_MON});
    QPLL_LOCK = 1'b0;
    repeat (2) tick();
    QPLL_LOCK = 1'b1;
    tick();
    QPLL_LOCK = 1'b0;
    repeat (3) tick();
    QPLL_LOCK = 1'b1;
    tick();
    chk("filt_interrupted", {13'd0, RSTRT_STATE}, {13'd0, S_MON});
    push_exp(1'b1);
    MMCM_LOCK = 1'b0;
    repeat (4) tick();
    MMCM_LOCK = 1'b1;
    chk("filt_4_restart", {13'd0, RSTRT_STATE}, {13'd0, S_RST});
    chk("filt_lock_lost", {15'd0, LOCK_LOST}, 16'd1);
    back_to_monitor();
    AUTO_EN = 1'b0;
    MMCM_LOCK = 1'b0;
    repeat (10) tick();
    MMCM_LOCK = 1'b1;
    chk("auto_dis_no_restart", {13'd0, RSTRT_STATE}, {13'd0, S_MON});

    // Scenario 3: two requests during Holdoff merge into one restart
    RUN = 1'b0;
    tick();
    chk("run_fall_idle", {13'd0, RSTRT_STATE}, {13'd0, S_IDLE});
    push_exp(1'b1);
    RUN = 1'b1;
    tick();
    chk("s3_holdoff", {13'd0, RSTRT_STATE}, {13'd0, S_HOLD});
    for (int i = 0; i < 8; i++) begin
      JTAG_RESTART = (i == 1 || i == 3);
      tick();
    end
    JTAG_RESTART = 1'b0;
    chk("pend_first_mon", {13'd0, RSTRT_STATE}, {13'd0, S_MON});
    tick();
    chk("pend_restart", {13'd0, RSTRT_STATE}, {13'd0, S_RST});

    // Scenario 4: RUN never returns -> Fail 20 cycles into W4Run
    RUN = 1'b0;
    tick();
    tick();
    chk("s4_w4run", {13'd0, RSTRT_STATE}, {13'd0, S_W4R});
    repeat (19) tick();
    chk("w4run_last", {13'd0, RSTRT_STATE}, {13'd0, S_W4R});
    tick();
    chk("w4run_fail", {13'd0, RSTRT_STATE}, {13'd0, S_FAIL});
    chk("fail_flag", {15'd0, RSTRT_FAIL}, 16'd1);
    JTAG_RESTART = 1'b1;
    tick();
    JTAG_RESTART = 1'b0;
    repeat (2) tick();
    chk("fail_holds", {13'd0, RSTRT_STATE}, {13'd0, S_FAIL});
    CLR_FAIL = 1'b1;
    tick();
    CLR_FAIL = 1'b0;
    chk("clr_fail_idle", {13'd0, RSTRT_STATE}, {13'd0, S_IDLE});
    chk("clr_fail_flag", {15'd0, RSTRT_FAIL}, 16'd0);
    goto_monitor();
    repeat (3) tick();
    chk("fail_jtag_ignored", {13'd0, RSTRT_STATE}, {13'd0, S_MON});

    // W4Drop timeout with RUN stuck high
    push_exp(1'b1);
    JTAG_RESTART = 1'b1;
    tick();
    JTAG_RESTART = 1'b0;
    tick();
    repeat (19) tick();
    chk("w4drop_last", {13'd0, RSTRT_STATE}, {13'd0, S_W4D});
    tick();
    chk("w4drop_fail", {13'd0, RSTRT_STATE}, {13'd0, S_FAIL});
    RUN = 1'b0;
    CLR_FAIL = 1'b1;
    tick();
    CLR_FAIL = 1'b0;
    chk("clr_fail_idle2", {13'd0, RSTRT_STATE}, {13'd0, S_IDLE});

    // Scenario 5: asynchronous reset during W4Drop
    goto_monitor();
    push_exp(1'b1);
    JTAG_RESTART = 1'b1;
    tick();
    JTAG_RESTART = 1'b0;
    tick();
    chk("s5_w4drop", {13'd0, RSTRT_STATE}, {13'd0, S_W4D});
    #2 EOS = 1'b0;
    #1;
    chk("async_state", {13'd0, RSTRT_STATE}, {13'd0, S_IDLE});
    chk("async_flags", {13'd0, RESTART_ALL, LOCK_LOST, RSTRT_FAIL}, 16'd0);
    chk("async_cnt", {8'd0, RSTRT_CNT}, 16'd0);
    exp_cnt = 8'd0;
    RUN = 1'b0;
    tick();
    EOS = 1'b1;
    tick();

    // Reset asserted while a command is being presented: no pulse may escape
    goto_monitor();
    JTAG_RESTART = 1'b1;
    #2 EOS = 1'b0;
    tick();
    JTAG_RESTART = 1'b0;
    RUN = 1'b0;
    tick();
    chk("abort_idle", {13'd0, RSTRT_STATE}, {13'd0, S_IDLE});
    EOS = 1'b1;
    tick();

    // Command coinciding with filter expiry is JTAG-triggered
    goto_monitor();
    AUTO_EN = 1'b1;
    MMCM_LOCK = 1'b0;
    repeat (3) tick();
    push_exp(1'b0);
    JTAG_RESTART = 1'b1;
    tick();
    JTAG_RESTART = 1'b0;
    MMCM_LOCK = 1'b1;
    AUTO_EN = 1'b0;
    chk("coincide_restart", {13'd0, RSTRT_STATE}, {13'd0, S_RST});
    chk("coincide_lock_lost", {15'd0, LOCK_LOST}, 16'd0);
    back_to_monitor();

    // Scenario 6: counter saturation
    for (int k = 0; k < 260; k++) begin
      do_restart(1'b0);
    end
    chk("cnt_saturate", {8'd0, RSTRT_CNT}, 16'd255);

    repeat (3) tick();
    chk("missing_restarts", exp_q.size(), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/restart_ctrl.md
RESTART_CTRL -- requirements
Module: restart_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): LOCK_FILT, 8'd16, consecutive lock-loss cycles that trigger a restart.
REQ-002 HOLDOFF, 16'd1000, cycles after RUN rises before lock monitoring starts.
REQ-003 RUN_TMO, 16'd50000, maximum cycles allowed in W4Drop and in W4Run.
REQ-004 Ports SHALL be (name, direction, width, meaning): CLK, in, 1, single system clock, all logic on its rising edge.
REQ-005 EOS, in, 1, reset; asynchronous, active-low (low forces reset).
REQ-006 RUN, in, 1, power-on sequencer is in its run state.
REQ-007 QPLL_LOCK and MMCM_LOCK, in, 1 each, clock-lock indicators, synchronous to CLK.
REQ-008 AUTO_EN, in, 1, enables automatic restart on lock loss.
REQ-009 JTAG_RESTART, in, 1, single-cycle restart command.
REQ-010 CLR_FAIL, in, 1, clears the Fail state.
REQ-011 RESTART_ALL, out, 1, registered single-cycle restart request to the sequencer.
REQ-012 LOCK_LOST, out, 1, sticky flag set by a lock-loss-triggered restart.
REQ-013 RSTRT_FAIL, out, 1, high while in Fail.
REQ-014 RSTRT_CNT, out, 8, saturating count of RESTART_ALL pulses issued.
REQ-015 RSTRT_STATE, out, 3, current state encoding.

Function
REQ-016 The FSM SHALL use these encodings: Idle=000, Holdoff=001, Monitor=010, Restart=011, W4Drop=100, W4Run=101, Fail=110; 111 SHALL go to Idle.
REQ-017 Idle SHALL wait with no timeout for RUN=1, then go to Holdoff.
REQ-018 Holdoff SHALL count HOLDOFF cycles, go to Monitor, and return to Idle if RUN falls first.
REQ-019 Monitor SHALL go to Restart on JTAG_RESTART or a pending flag; if AUTO_EN=1 and lock loss persists (!QPLL_LOCK or !MMCM_LOCK) for LOCK_FILT consecutive cycles, it SHALL go to Restart and set LOCK_LOST; if RUN falls, it SHALL go to Idle.
REQ-020 The lock-loss filter counter SHALL clear on any cycle with both locks high, whenever AUTO_EN=0, and outside Monitor.
REQ-021 Restart SHALL last exactly 1 cycle, then go to W4Drop.
REQ-022 RESTART_ALL SHALL be decoded from nextstate==Restart and registered, so it is high for exactly the one cycle the FSM is in Restart.
REQ-023 W4Drop SHALL go to W4Run when RUN=0, and to Fail if RUN is still high after RUN_TMO cycles.
REQ-024 W4Run SHALL go to Holdoff when RUN=1, and to Fail after RUN_TMO cycles.
REQ-025 Fail SHALL go to Idle only on CLR_FAIL=1; RSTRT_FAIL SHALL be registered from nextstate==Fail.
REQ-026 A JTAG_RESTART arriving in Idle, Holdoff, Restart, W4Drop or W4Run SHALL set a one-deep pending flag; extra requests SHALL merge into it.
REQ-027 The pending flag SHALL clear on entry to Restart and on entry to Fail; JTAG_RESTART in Fail SHALL be ignored.
REQ-028 If JTAG_RESTART and a filter expiry coincide, the restart SHALL be JTAG-triggered and LOCK_LOST SHALL stay unchanged.
REQ-029 The timer SHALL be a 16-bit up-counter that clears on every state change and runs only in Holdoff, W4Drop and W4Run.
REQ-030 RSTRT_CNT SHALL increment once per RESTART_ALL pulse and hold at 8'hFF.
REQ-031 LOCK_LOST SHALL clear only on reset.

Reset
REQ-032 While EOS=0, state SHALL be Idle; RESTART_ALL, RSTRT_FAIL, LOCK_LOST, the pending flag, the filter counter, the timer and RSTRT_CNT SHALL all be 0.
REQ-033 EOS falling mid-operation SHALL abort any sequence immediately, with no RESTART_ALL pulse emitted.
REQ-034 EOS SHALL be sampled directly with no synchronizer; release is synchronized upstream.

Structure
REQ-035 State encodings and parameter defaults SHALL live in shared package rstrt_pkg.
REQ-036 The lock-loss filter SHALL be sub-module lock_filt (inputs: clear, loss; output: expired; LOCK_FILT parameter).
REQ-037 Implementation SHALL use one comb nextstate block plus registered outputs decoded from nextstate.

Verification (LOCK_FILT=4, HOLDOFF=8, RUN_TMO=20)
REQ-038 Scenario 1: RUN rises, then JTAG_RESTART 12 cycles later -> RESTART_ALL high for 1 cycle, RSTRT_CNT=1, LOCK_LOST=0.
REQ-039 Scenario 2: in Monitor with AUTO_EN=1, MMCM_LOCK low for 3 cycles -> no restart; low for 4 cycles -> restart with LOCK_LOST=1.
REQ-040 Scenario 3: JTAG_RESTART during Holdoff -> restart issued in the first Monitor cycle; two requests during Holdoff -> only one pulse.
REQ-041 Scenario 4: RUN never rises after restart -> Fail exactly 20 cycles after entering W4Run; CLR_FAIL -> Idle.
REQ-042 Scenario 5: EOS low during W4Drop -> all outputs 0, state 000 asynchronously.
REQ-043 Scenario 6: 260 restarts -> RSTRT_CNT saturates at 255.
